// File: rtl/cpu_fetch_sequencer.sv
// Fetch sequencer: reads opcode plus operand bytes at the PC, classifies the opcode and issues the instruction.
// Latency: len+1 cycles per instruction with zero-wait memory. Backpressure: holds ISSUE until insn_ready.
// Optional opcode prefetch buffer enabled by defining CPU_FETCH_PREFETCH_EN.
module cpu_fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [2:0]  insn_group,
    output logic [2:0]  insn_len,
    output logic [31:0] insn_bytes,
    output logic [15:0] insn_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, FETCH_FIRST, FETCH_OPERAND, ISSUE} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc;
    logic [1:0]  rem;
    logic [1:0]  idx;
    logic        accept;
    logic        mem_hit;
    logic        pf_hit;
    logic [7:0]  pf_byte;
    logic [15:0] pf_pc;
    logic [7:0]  dec_byte;
    logic [5:0]  dec;
    logic [2:0]  dec_len;
    logic        load_opcode;

    // Group is the trailing-ones count minus one, with counts 0 and 1 merged into group 0.
    function automatic logic [5:0] decode(input logic [7:0] op);
        logic [3:0] t;
        logic [2:0] g;
        logic [2:0] l;
        t = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (op[i] && (t == i[3:0])) t = t + 4'd1;
        end
        g = (t <= 4'd1) ? 3'd0 : (t[2:0] - 3'd1);
        l = (g == 3'd5) ? 3'd4 : ((g == 3'd7) ? 3'd1 : 3'd2);
        return {g, l};
    endfunction

    assign accept     = insn_valid && insn_ready;
    assign mem_hit    = mem_req && mem_ack;
    assign mem_addr   = pc;
    assign insn_valid = (state == ISSUE);

`ifdef CPU_FETCH_PREFETCH_EN
    logic        buf_vld;
    logic [7:0]  buf_dat;
    logic [15:0] buf_pc;

    assign mem_req = (state == FETCH_FIRST) || (state == FETCH_OPERAND) ||
                     ((state == ISSUE) && !buf_vld);
    // A byte arriving in the accepting cycle is decoded directly, bypassing the buffer.
    assign pf_hit  = buf_vld || mem_hit;
    assign pf_byte = buf_vld ? buf_dat : mem_rdata;
    assign pf_pc   = buf_vld ? buf_pc : pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld <= 1'b0;
            buf_dat <= 8'h00;
            buf_pc  <= 16'h0000;
        end else if (redirect) begin
            buf_vld <= 1'b0;
        end else if (state == ISSUE) begin
            if (accept) begin
                buf_vld <= 1'b0;
            end else if (mem_hit) begin
                buf_vld <= 1'b1;
                buf_dat <= mem_rdata;
                buf_pc  <= pc;
            end
        end
    end
`else
    assign mem_req = (state == FETCH_FIRST) || (state == FETCH_OPERAND);
    assign pf_hit  = 1'b0;
    assign pf_byte = mem_rdata;
    assign pf_pc   = pc;
`endif

    assign dec_byte    = (state == ISSUE) ? pf_byte : mem_rdata;
    assign dec         = decode(dec_byte);
    assign dec_len     = dec[2:0];
    assign load_opcode = ((state == FETCH_FIRST) && mem_hit) ||
                         ((state == ISSUE) && accept && pf_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:          state_nxt = FETCH_FIRST;
            FETCH_FIRST:   if (mem_hit) state_nxt = (dec_len == 3'd1) ? ISSUE : FETCH_OPERAND;
            FETCH_OPERAND: if (mem_hit && (rem == 2'd1)) state_nxt = ISSUE;
            ISSUE: begin
                if (accept) begin
                    if (pf_hit) state_nxt = (dec_len == 3'd1) ? ISSUE : FETCH_OPERAND;
                    else        state_nxt = FETCH_FIRST;
                end
            end
            default:       state_nxt = IDLE;
        endcase
        // A redirect wins over everything, including a simultaneous read completion.
        if (redirect) state_nxt = FETCH_FIRST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            insn_group <= 3'd0;
            insn_len   <= 3'd0;
            insn_bytes <= 32'h0;
            insn_pc    <= 16'h0000;
            rem        <= 2'd0;
            idx        <= 2'd0;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else begin
            if (mem_hit) pc <= pc + 16'd1;
            if (load_opcode) begin
                insn_bytes <= {24'h0, dec_byte};
                insn_pc    <= (state == ISSUE) ? pf_pc : pc;
                insn_group <= dec[5:3];
                insn_len   <= dec_len;
                rem        <= dec_len[1:0] - 2'd1;
                idx        <= 2'd1;
            end else if ((state == FETCH_OPERAND) && mem_hit) begin
                insn_bytes[{idx, 3'b000} +: 8] <= mem_rdata;
                idx <= idx + 2'd1;
                rem <= rem - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Directed bench for cpu_fetch_sequencer against a byte memory model with programmable wait states.
module tb_cpu_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic [2:0]  insn_group;
    logic [2:0]  insn_len;
    logic [31:0] insn_bytes;
    logic [15:0] insn_pc;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;

    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          errors = 0;
    int          wait_n = 0;
    int          wcnt = 0;
    int          addr_viol = 0;

    cpu_fetch_sequencer #(.RESET_PC(16'h0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .insn_valid(insn_valid), .insn_ready(insn_ready),
        .insn_group(insn_group), .insn_len(insn_len), .insn_bytes(insn_bytes), .insn_pc(insn_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    assign mem_ack   = mem_req && (wcnt >= wait_n);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic redirect_to(input logic [15:0] a);
        redirect    = 1'b1;
        redirect_pc = a;
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    // Waits for insn_valid; also counts any change of a pending request's address.
    task automatic wait_valid(input string tag);
        int          n;
        logic        pend;
        logic [15:0] pend_addr;
        n         = 0;
        pend      = mem_req && !mem_ack;
        pend_addr = mem_addr;
        while (!insn_valid && n < 60) begin
            @(negedge clk);
            if (pend && (!mem_req || mem_addr !== pend_addr)) addr_viol++;
            pend      = mem_req && !mem_ack;
            pend_addr = mem_addr;
            n++;
        end
        check({tag, "_valid"}, {31'b0, insn_valid}, 32'd1);
    endtask

    task automatic accept_insn();
        insn_ready = 1'b1;
        @(negedge clk);
        insn_ready = 1'b0;
    endtask

    task automatic expect_insn(input string tag, input logic [2:0] g, input logic [2:0] l,
                               input logic [31:0] b, input logic [15:0] p);
        check({tag, "_group"}, {29'b0, insn_group}, {29'b0, g});
        check({tag, "_len"},   {29'b0, insn_len},   {29'b0, l});
        check({tag, "_bytes"}, insn_bytes, b);
        check({tag, "_pc"},    {16'b0, insn_pc},    {16'b0, p});
    endtask

    logic [7:0] ops  [7] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h7F};
    logic [2:0] grps [7] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};

    initial begin
        int          nreq;
        int          unstable;
        int          exp_req;
        logic [15:0] a;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0100] = 8'hFF;
        mem[16'h0200] = 8'h3F; mem[16'h0201] = 8'h05; mem[16'h0202] = 8'h34; mem[16'h0203] = 8'h12;
        for (int i = 0; i < 7; i++) begin
            a = 16'h3000 + 16'(i * 16);
            mem[a]         = ops[i];
            mem[a + 16'd1] = 8'hA0 + 8'(i);
        end
        mem[16'h0500] = 8'h3F; mem[16'h0501] = 8'h11; mem[16'h0502] = 8'h22; mem[16'h0503] = 8'h33;
        mem[16'h4000] = 8'hFF;
        mem[16'hFFFF] = 8'h01; mem[16'h0000] = 8'h5A; mem[16'h0001] = 8'hFF;

        repeat (2) @(negedge clk);
        check("rst_addr",  {16'b0, mem_addr}, 32'h0100);
        check("rst_req",   {31'b0, mem_req}, 32'd0);
        check("rst_valid", {31'b0, insn_valid}, 32'd0);
        expect_insn("rst", 3'd0, 3'd0, 32'h0, 16'h0000);

        rst_n = 1'b1;
        @(negedge clk);
        check("first_req",    {31'b0, mem_req}, 32'd1);
        check("first_nvalid", {31'b0, insn_valid}, 32'd0);
        @(negedge clk);
        check("c3_valid", {31'b0, insn_valid}, 32'd1);
        expect_insn("c3", 3'd7, 3'd1, 32'h000000FF, 16'h0100);

        nreq = 0;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req) nreq++;
            if (!insn_valid || insn_bytes !== 32'hFF || insn_pc !== 16'h0100 ||
                insn_group !== 3'd7 || insn_len !== 3'd1) unstable++;
            @(negedge clk);
        end
`ifdef CPU_FETCH_PREFETCH_EN
        exp_req = 1;
`else
        exp_req = 0;
`endif
        check("hold_stable", unstable, 0);
        check("hold_req",    nreq, exp_req);
        accept_insn();

        for (int w = 0; w < 4; w++) begin
            wait_n = w;
            redirect_to(16'h0200);
            wait_valid("rm");
            expect_insn("rm", 3'd5, 3'd4, 32'h1234053F, 16'h0200);
            accept_insn();
        end
        check("addr_stable", addr_viol, 0);
        wait_n = 0;

        for (int i = 0; i < 7; i++) begin
            a = 16'h3000 + 16'(i * 16);
            redirect_to(a);
            wait_valid("op");
            expect_insn("op", grps[i], 3'd2, {16'h0, 8'hA0 + 8'(i), ops[i]}, a);
            accept_insn();
        end

        redirect_to(16'h0500);
        @(negedge clk);
        check("ro_addr", {16'b0, mem_addr}, 32'h0501);
        check("ro_ack",  {31'b0, mem_ack}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h4000;
        @(negedge clk);
        redirect    = 1'b0;
        check("ro_newaddr", {16'b0, mem_addr}, 32'h4000);
        check("ro_req",     {31'b0, mem_req}, 32'd1);
        check("ro_nvalid",  {31'b0, insn_valid}, 32'd0);
        wait_valid("ro");
        expect_insn("ro", 3'd7, 3'd1, 32'h000000FF, 16'h4000);
        accept_insn();

        redirect_to(16'hFFFF);
        wait_valid("wrap");
        expect_insn("wrap", 3'd0, 3'd2, 32'h00005A01, 16'hFFFF);
        accept_insn();
        wait_valid("wrap2");
        expect_insn("wrap2", 3'd7, 3'd1, 32'h000000FF, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

endmodule
